// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - MEM-stage request / data-memory bus between pipeline and mem_access_unit
//
// Purpose : bundles the MEM-stage request, the data-memory port and the
//           load/status results into a single bus.
// Modports: master - MEM stage / memory side (drives req_*, dm_rdata, pc)
//           slave  - mem_access_unit (drives dm_*, load_*, stall, addr_err, err_sticky)
// Config  : MEM_TRACE_EN adds the pc signal.

interface mem_access_unit_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef MEM_TRACE_EN
    logic [31:0] pc;
`endif
    logic [31:0] dm_rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        addr_err;
    logic        err_sticky;

    modport master (
`ifdef MEM_TRACE_EN
        output pc,
`endif
        output req_valid, req_op, req_addr, req_wdata, dm_rdata,
        input  dm_addr, dm_wdata, dm_we, load_data, load_valid,
        input  stall, addr_err, err_sticky
    );

    modport slave (
`ifdef MEM_TRACE_EN
        input  pc,
`endif
        input  req_valid, req_op, req_addr, req_wdata, dm_rdata,
        output dm_addr, dm_wdata, dm_we, load_data, load_valid,
        output stall, addr_err, err_sticky
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end with sub-word read-modify-write and address checking
//
// Purpose : decodes the MEM-stage load/store, drives the word-wide data
//           memory, extends load results, performs SH/SB as a two-cycle
//           read-modify-write (one stall cycle) and flags misaligned or
//           out-of-range accesses.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - mem_access_unit_if.slave (request, DM port, load result,
//                   stall, addr_err, err_sticky; pc with MEM_TRACE_EN)
// Config  : MEM_TRACE_EN - adds the pc signal and prints a simulation-only
//           "@pc: *addr <= data" line for every DM write.

module mem_access_unit #(
    parameter int DM_SIZE = 3072
) (
    input  logic clk,
    input  logic reset,
    mem_access_unit_if.slave bus
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [29:0] DM_LIMIT = 30'(DM_SIZE);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state, next_state;
    logic [31:0] rmw_addr;
    logic [31:0] rmw_data;
    logic        err_q;
`ifdef MEM_TRACE_EN
    logic [31:0] pc_q;
`endif

    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        addr_err;
    logic        capture;
    logic [31:0] merged;
    logic        misaligned;
    logic        out_of_range;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Lane selection is little-endian: byte lane 0 is bits 7:0.
    assign rd_byte = bus.dm_rdata[{bus.req_addr[1:0], 3'b000} +: 8];
    assign rd_half = bus.dm_rdata[{bus.req_addr[1], 4'b0000} +: 16];

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_op)
            OP_LW, OP_SW:         misaligned = |bus.req_addr[1:0];
            OP_LH, OP_LHU, OP_SH: misaligned = bus.req_addr[0];
            default:              misaligned = 1'b0;
        endcase
        out_of_range = (bus.req_addr[31:2] >= DM_LIMIT);
    end

    always_comb begin
        next_state = state;
        dm_addr    = {bus.req_addr[31:2], 2'b00};
        dm_wdata   = bus.req_wdata;
        dm_we      = 1'b0;
        load_data  = 32'h0;
        load_valid = 1'b0;
        stall      = 1'b0;
        addr_err   = 1'b0;
        capture    = 1'b0;
        merged     = bus.dm_rdata;

        // Sub-word merge into the word currently read from DM.
        if (bus.req_op == OP_SB)
            merged[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
        else
            merged[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];

        if (reset) begin
            // Outputs go inactive as soon as reset rises, even mid-RMW.
            next_state = IDLE;
        end else if (state == RMW_WR) begin
            // The MEM stage still holds the same store here; req_* is ignored.
            dm_addr    = rmw_addr;
            dm_wdata   = rmw_data;
            dm_we      = 1'b1;
            next_state = IDLE;
        end else if (bus.req_valid) begin
            if (misaligned || out_of_range) begin
                addr_err = 1'b1;
            end else begin
                case (bus.req_op)
                    OP_LW: begin
                        load_valid = 1'b1;
                        load_data  = bus.dm_rdata;
                    end
                    OP_LH: begin
                        load_valid = 1'b1;
                        load_data  = {{16{rd_half[15]}}, rd_half};
                    end
                    OP_LHU: begin
                        load_valid = 1'b1;
                        load_data  = {16'h0, rd_half};
                    end
                    OP_LB: begin
                        load_valid = 1'b1;
                        load_data  = {{24{rd_byte[7]}}, rd_byte};
                    end
                    OP_LBU: begin
                        load_valid = 1'b1;
                        load_data  = {24'h0, rd_byte};
                    end
                    OP_SW: begin
                        dm_we = 1'b1;
                    end
                    default: begin
                        // SH/SB: read cycle; the merged word is written next cycle.
                        stall      = 1'b1;
                        capture    = 1'b1;
                        next_state = RMW_WR;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rmw_addr <= 32'h0;
            rmw_data <= 32'h0;
            err_q    <= 1'b0;
`ifdef MEM_TRACE_EN
            pc_q     <= 32'h0;
`endif
        end else begin
            state <= next_state;
            if (capture) begin
                rmw_addr <= dm_addr;
                rmw_data <= merged;
`ifdef MEM_TRACE_EN
                pc_q     <= bus.pc;
`endif
            end
            if (addr_err)
                err_q <= 1'b1;
        end
    end

`ifdef MEM_TRACE_EN
    // Simulation-only write trace; a sub-word store reports the pc of its read cycle.
    always @(posedge clk) begin
        if (!reset && dm_we)
            $display("@%h: *%h <= %h", (state == RMW_WR) ? pc_q : bus.pc, dm_addr, dm_wdata);
    end
`endif

    assign bus.dm_addr    = dm_addr;
    assign bus.dm_wdata   = dm_wdata;
    assign bus.dm_we      = dm_we;
    assign bus.load_data  = load_data;
    assign bus.load_valid = load_valid;
    assign bus.stall      = stall;
    assign bus.addr_err   = addr_err;
    assign bus.err_sticky = err_q;

endmodule
